// File: rtl/jio_kbd.sv
// jio_kbd: keyboard-style input responder for the jcscpu IO protocol.
// The operator keys a byte on SW and presses BTN. Each press queues one byte in a
// small FIFO. When this device is selected, the CPU reads the bytes back through
// data-read windows and reads flags through status-read windows.
//
// Handshake: the CPU strobes (io_s, io_e) are levels held for many CLK cycles.
// Address select acts on the registered rising edge of the OUT-address strobe.
// A data read shows the FIFO head for as long as the window is open. The pop
// (consume) happens on the first clock after the window closes, so the value on
// the bus stays stable for the whole enable. bus_out is 8'h00 whenever this
// device is not driving, so it can be wired-OR onto the shared bus.
module jio_kbd #(
    parameter logic [7:0] DEV_ADDR = 8'h01,
    parameter int         DEPTH    = 4,
    parameter int         AW       = 2
) (
    input  logic          CLK,
    input  logic          resetn,
    input  logic [7:0]    SW,
    input  logic          BTN,
    input  logic          io_s,
    input  logic          io_e,
    input  logic          io_da,
    input  logic          io_io,
    input  logic [7:0]    bus_in,
    output logic [7:0]    bus_out,
    output logic          selected,
    output logic [AW:0]   count,
    output logic          ovf
);

    // FIFO storage and pointers
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    // BTN synchronizer (btn_s1, btn_s2) and the history bit used for edge detection
    logic btn_s1, btn_s2, btn_prev;

    // registered address-strobe history and read-window history
    logic asel_q, asel_prev;
    logic rd_prev, st_prev;

    // decoded events
    logic asel_raw, asel_ev;
    logic rd_win, st_win;
    logic push_ev, pop_ev, st_clr;
    logic full, empty;
    logic accept, pop_eff;
    logic [3:0] cnt4;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign cnt4  = 4'(count);

    assign asel_raw = io_s & io_da & io_io;
    assign asel_ev  = asel_q & ~asel_prev;

    assign rd_win = selected & io_e & ~io_da & ~io_io;
    assign st_win = selected & io_e &  io_da & ~io_io;

    assign push_ev = btn_s2 & ~btn_prev;
    assign pop_ev  = rd_prev & ~rd_win;
    assign st_clr  = st_prev & ~st_win;

    // A pop from an empty FIFO does nothing. A push into a full FIFO is taken only
    // when a pop frees a slot at the same edge.
    assign pop_eff = pop_ev & ~empty;
    assign accept  = push_ev & (~full | pop_eff);

    // Drive the bus only while a read window is open. In every other case the bus is 0.
    always_comb begin
        bus_out = 8'h00;
        if (rd_win) begin
            bus_out = empty ? 8'h00 : mem[rp];
        end else if (st_win) begin
            bus_out = {full, empty, ovf, 1'b0, cnt4};
        end
    end

    // Write an accepted byte into the FIFO. The storage has no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wp] <= SW;
        end
    end

    // Control state: synchronizers, strobe history, selection, pointers, count and overflow
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_prev  <= 1'b0;
            asel_q    <= 1'b0;
            asel_prev <= 1'b0;
            rd_prev   <= 1'b0;
            st_prev   <= 1'b0;
            selected  <= 1'b0;
            ovf       <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
        end else begin
            btn_s1    <= BTN;
            btn_s2    <= btn_s1;
            btn_prev  <= btn_s2;
            asel_q    <= asel_raw;
            asel_prev <= asel_q;
            rd_prev   <= rd_win;
            st_prev   <= st_win;

            if (asel_ev) begin
                selected <= (bus_in == DEV_ADDR);
            end

            if (accept) begin
                wp <= wp + AW'(1);
            end
            if (pop_eff) begin
                rp <= rp + AW'(1);
            end

            case ({accept, pop_eff})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            // If a new overflow and a status clear happen at the same edge, the overflow wins.
            if (push_ev && !accept) begin
                ovf <= 1'b1;
            end else if (st_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/jio_kbd.md
Name: jio_kbd

Overview:
- Input-side IO responder for the jcscpu IO protocol; it is the counterpart of the output-only TTY handling in the top level.
- The operator keys a byte on the switches and presses a button. The byte is queued in a small FIFO.
- The CPU selects this device with OUT-address (io_s, io_da=1, io_io=1) and reads it with IN-data (io_e, io_da=0, io_io=0) or IN-address/status (io_e, io_da=1, io_io=0).
- The block drives its byte onto the shared wired-OR bus.

Parameters:
- DEV_ADDR, 8'h01, IO device address this block answers to.
- DEPTH, 4, FIFO entries; must be a power of two, 2..8.
- AW, 2, log2(DEPTH).

Ports:
- CLK  in  1  fast system clock; all logic is on posedge CLK.
- resetn  in  1  asynchronous, active-low reset.
- SW  in  8  data byte to enqueue (raw switches, quasi-static).
- BTN  in  1  raw enqueue button, asynchronous to CLK.
- io_s  in  1  CPU IO set strobe; level, held for many CLK cycles.
- io_e  in  1  CPU IO enable strobe; level, held for many CLK cycles.
- io_da  in  1  1 = address/status cycle, 0 = data cycle.
- io_io  in  1  1 = output (CPU to device), 0 = input (device to CPU).
- bus_in  in  8  CPU bus value, sampled on address select.
- bus_out  out  8  byte driven toward the CPU bus; 8'h00 when not driving (wired-OR safe).
- selected  out  1  device is the currently addressed IO device.
- count  out  AW+1  FIFO occupancy.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (resetn=0, async): FIFO pointers=0, count=0, selected=0, ovf=0, bus_out=0, all edge-detector history=0.
- BTN path: 2-flop synchronizer, then rising-edge detect. One push per press.
  - Push: mem[wp]<=SW, wp+1 mod DEPTH, count+1.
  - Push when full: byte dropped, ovf<=1, pointers and count unchanged.
- Address select fires on the rising edge of (io_s & io_da & io_io) after registering the strobe.
  - selected <= (bus_in == DEV_ADDR).
  - Any other address deselects. Selection persists until the next address select.
- Data read window: selected & io_e & !io_da & !io_io.
  - bus_out = mem[rp] combinationally while the window is high; 8'h00 if empty.
  - Pop happens on the falling edge of the window (registered strobe history). The value is therefore stable for the whole enable.
  - Pop: rp+1 mod DEPTH, count-1. Pop while empty is a no-op.
- Status read window: selected & io_e & io_da & !io_io.
  - bus_out = {full, empty, ovf, 1'b0, count zero-extended/truncated to 4 bits}.
  - ovf clears on the falling edge of this window.
  - A new overflow in the same cycle as the clear wins: ovf stays 1.
- Push and pop in the same cycle: both take effect. count is unchanged, data is correct.
  - Full with simultaneous pop: the push is accepted, no ovf.
- Derived flags: full = (count==DEPTH), empty = (count==0). Pointers wrap modulo DEPTH.
- Output writes to this device (io_s, io_da=0, io_io=1) are ignored.
- bus_out is 0 whenever no read window is active or selected=0.
- Reset asserted mid-read: bus_out goes to 0 immediately and no pop occurs.

Test Plan:
- Reset, then address-select with bus_in=8'h01 → selected=1. Status read → bus_out=8'h40 (empty), count=0.
- Press BTN with SW=8'hA5, then SW=8'h3C → count=2. Data read → bus_out=8'hA5 for the whole io_e, count=1 after io_e falls. Next read → 8'h3C, count=0.
- Five presses with DEPTH=4 (SW=1,2,3,4,5) → count=4, ovf=1, status=8'hA4. Status read clears ovf. Reads return 1,2,3,4; the byte 5 is lost.
- Address-select with 8'h00, then data read → bus_out stays 8'h00 and count is unchanged. Reselect 8'h01 → the read succeeds.
- With FIFO full, BTN edge coincides with the pop falling edge → count stays 4, ovf=0, new byte appears after the 3 older entries.
- Hold BTN high across 20 cycles → exactly one push. Assert resetn=0 during an active read → bus_out=0 asynchronously, count=0.
